// File: rtl/tc_accum_rd_unit_pkg.sv
// tc_accum_rd_unit_pkg: default sizes, FSM state encoding and read-source selects for the accumulator read unit
package tc_accum_rd_unit_pkg;
  localparam int ACC_LEN_DEF = 8;
  localparam int TC_NUM_DEF = 16;
  localparam int ADDR_LEN_DEF = 4;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;
  localparam logic SRC_LIVE = 1'b0;
  localparam logic SRC_SHADOW = 1'b1;
endpackage

// File: rtl/tc_accum_shadow.sv
// tc_accum_shadow: TC_NUM x ACC_LEN snapshot bank; snap_req captures acc_in, rd_idx reads the pre-edge entry, snap_valid sticks until reset
module tc_accum_shadow
  import tc_accum_rd_unit_pkg::*;
#(
  parameter int ACC_LEN = ACC_LEN_DEF,
  parameter int TC_NUM = TC_NUM_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      snap_req,
  input  logic [ACC_LEN*TC_NUM-1:0] acc_in,
  input  logic [ADDR_LEN-1:0]       rd_idx,
  output logic [ACC_LEN-1:0]        rd_data,
  output logic                      snap_valid
);
  logic [TC_NUM-1:0][ACC_LEN-1:0] bank_d, bank_q;
  logic snap_valid_d, snap_valid_q;
  always_comb begin
    bank_d = snap_req ? acc_in : bank_q;
    snap_valid_d = snap_valid_q | snap_req;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      snap_valid_q <= snap_valid_d;
    end
  end
  assign rd_data = bank_q[rd_idx];
  assign snap_valid = snap_valid_q;
endmodule

// File: rtl/tc_accum_rd_unit.sv
// tc_accum_rd_unit: selects a live or snapshot channel by rd_addr/rd_src and returns it via rd_req/rd_ready -> rd_valid/rd_data/rd_err/rd_ack
module tc_accum_rd_unit
  import tc_accum_rd_unit_pkg::*;
#(
  parameter int ACC_LEN = ACC_LEN_DEF,
  parameter int TC_NUM = TC_NUM_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ACC_LEN*TC_NUM-1:0] tc_acc_in,
  input  logic                      snap_req,
  input  logic                      rd_req,
  input  logic [ADDR_LEN-1:0]       rd_addr,
  input  logic                      rd_src,
  output logic                      rd_ready,
  output logic                      rd_valid,
  output logic [ACC_LEN-1:0]        rd_data,
  output logic                      rd_err,
  input  logic                      rd_ack,
  output logic                      snap_valid
);
  logic [TC_NUM-1:0][ACC_LEN-1:0] live;
  logic [ACC_LEN-1:0] shadow_data, sel_data, data_d, data_q;
  logic err, err_d, err_q, accept;
  state_e state_d, state_q;
  assign live = tc_acc_in;
  tc_accum_shadow #(.ACC_LEN(ACC_LEN), .TC_NUM(TC_NUM), .ADDR_LEN(ADDR_LEN)) u_shadow (
    .clk(clk),
    .reset(reset),
    .snap_req(snap_req),
    .acc_in(tc_acc_in),
    .rd_idx(rd_addr),
    .rd_data(shadow_data),
    .snap_valid(snap_valid)
  );
  always_comb begin
    accept = state_q == IDLE && rd_req;
    err = 32'(rd_addr) >= 32'(TC_NUM) || (rd_src == SRC_SHADOW && !snap_valid);
    sel_data = err ? '0 : rd_src == SRC_SHADOW ? shadow_data : live[rd_addr];
    state_d = accept ? RESP : (state_q == RESP && rd_ack) ? IDLE : state_q;
    data_d = accept ? sel_data : data_q;
    err_d = accept ? err : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign rd_ready = state_q == IDLE;
  assign rd_valid = state_q == RESP;
  assign rd_data = data_q;
  assign rd_err = err_q;
endmodule

// File: tb/tb_tc_accum_rd_unit.sv
// tb_tc_accum_rd_unit: table-driven reads with a response scoreboard plus back-pressure and reset-in-response sequences
module tb_tc_accum_rd_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [127:0] tc_acc_in = '0;
  logic snap_req = 1'b0;
  logic rd_req = 1'b0;
  logic [3:0] rd_addr = '0;
  logic rd_src = 1'b0;
  logic rd_ready, rd_valid, rd_err, snap_valid;
  logic [7:0] rd_data;
  logic rd_ack = 1'b0;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [7:0] d; logic e;} exp_t;
  exp_t sb[$];
  typedef struct {
    logic [3:0] addr;
    logic src;
    logic snap_pre;
    logic snap_with;
    logic [7:0] base;
    logic [7:0] exp_d;
    logic exp_e;
  } vec_t;
  vec_t vecs[9];
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  tc_accum_rd_unit dut (
    .clk(clk), .reset(reset), .tc_acc_in(tc_acc_in), .snap_req(snap_req),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_src(rd_src), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_ack(rd_ack),
    .snap_valid(snap_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got data %0h err %0b with no request pending", rd_data, rd_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", 32'(rd_data), 32'(e.d));
        chk("resp_err", 32'(rd_err), 32'(e.e));
      end
    end
    prev_v = rd_valid;
  end

  task automatic set_live(input logic [7:0] base);
    for (int k = 0; k < 16; k++) tc_acc_in[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic issue(input logic [3:0] a, input logic s, input logic sn, input logic [7:0] ed, input logic ee);
    int n = 0;
    rd_addr = a;
    rd_src = s;
    rd_req = 1'b1;
    snap_req = sn;
    while (!rd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rd_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: rd_ready stayed 0 for %0d cycles, expected 1", n);
    end else sb.push_back('{ed, ee});
    @(negedge clk);
    rd_req = 1'b0;
    snap_req = 1'b0;
  endtask

  task automatic ack_resp();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("valid_after_ack", 32'(rd_valid), 32'd0);
    chk("ready_after_ack", 32'(rd_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'd5,  1'b0, 1'b0, 1'b0, 8'h10, 8'h15, 1'b0};
    vecs[1] = '{4'd3,  1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1};
    vecs[2] = '{4'd7,  1'b1, 1'b1, 1'b0, 8'hA0, 8'h17, 1'b0};
    vecs[3] = '{4'd7,  1'b0, 1'b0, 1'b0, 8'hA0, 8'hA7, 1'b0};
    vecs[4] = '{4'd7,  1'b1, 1'b0, 1'b1, 8'hA0, 8'h17, 1'b0};
    vecs[5] = '{4'd7,  1'b1, 1'b0, 1'b0, 8'hA0, 8'hA7, 1'b0};
    vecs[6] = '{4'd0,  1'b1, 1'b0, 1'b0, 8'h60, 8'hA0, 1'b0};
    vecs[7] = '{4'd15, 1'b0, 1'b0, 1'b0, 8'h60, 8'h6F, 1'b0};
    vecs[8] = '{4'd12, 1'b1, 1'b0, 1'b0, 8'h60, 8'hAC, 1'b0};
    set_live(8'h10);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rd_ready), 32'd1);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_err", 32'(rd_err), 32'd0);
    chk("rst_snap_valid", 32'(snap_valid), 32'd0);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("idle_ack_ready", 32'(rd_ready), 32'd1);
    chk("idle_ack_valid", 32'(rd_valid), 32'd0);
    foreach (vecs[i]) begin
      if (vecs[i].snap_pre) begin
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        chk("snap_valid_set", 32'(snap_valid), 32'd1);
      end
      set_live(vecs[i].base);
      issue(vecs[i].addr, vecs[i].src, vecs[i].snap_with, vecs[i].exp_d, vecs[i].exp_e);
      chk("vec_valid", 32'(rd_valid), 32'd1);
      chk("vec_ready", 32'(rd_ready), 32'd0);
      ack_resp();
    end
    set_live(8'h40);
    issue(4'd2, 1'b0, 1'b0, 8'h42, 1'b0);
    rd_req = 1'b1;
    rd_addr = 4'd9;
    for (int i = 0; i < 4; i++) begin
      set_live(8'h30 + 8'(i * 16));
      @(negedge clk);
      chk("bp_valid", 32'(rd_valid), 32'd1);
      chk("bp_ready", 32'(rd_ready), 32'd0);
      chk("bp_data", 32'(rd_data), 32'h42);
    end
    rd_req = 1'b0;
    ack_resp();
    repeat (3) @(negedge clk);
    chk("bp_no_queued_req", 32'(rd_valid), 32'd0);
    set_live(8'h10);
    issue(4'd9, 1'b0, 1'b0, 8'h19, 1'b0);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_ready", 32'(rd_ready), 32'd1);
    chk("mid_rst_data", 32'(rd_data), 32'd0);
    chk("mid_rst_snap_valid", 32'(snap_valid), 32'd0);
    issue(4'd15, 1'b0, 1'b0, 8'h1F, 1'b0);
    ack_resp();
    issue(4'd7, 1'b1, 1'b0, 8'h00, 1'b1);
    ack_resp();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
